// File: rtl/seq_detect_prog.sv
// Programmable Moore serial pattern detector: 1..MAX_LEN bit pattern loaded at run time,
// overlapping or non-overlapping detection, saturating hit counter.
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               ovl_in,
    input  logic               en,
    input  logic               x,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    state_t             state;
    state_t             state_nx;

    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic               load_ok;
    logic [LEN_W-1:0]   len_eff;
    logic               sampling;
    logic [MAX_LEN-1:0] hist_nx;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] mask;
    logic               hit_next;
    logic               cnt_full;

    // Shared datapath decode; only the low len bits of history take part in the compare.
    always_comb begin
        load_ok  = load && (len_in != '0);
        len_eff  = (len_in > MAX_LEN_W) ? MAX_LEN_W : len_in;
        sampling = !load && en && (state != IDLE);
        hist_nx  = {hist[MAX_LEN-2:0], x};
        fill_inc = (fill >= MAX_LEN_W) ? MAX_LEN_W : fill + LEN_W'(1);
        mask     = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len));
        end
        hit_next = sampling && (fill_inc >= len) && (((hist_nx ^ pat) & mask) == '0);
        cnt_full = &match_cnt;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; load wins over sampling
    always_comb begin
        state_nx = state;
        if (load) begin
            state_nx = load_ok ? RUN : IDLE;
        end else begin
            case (state)
                IDLE:     state_nx = IDLE;
                RUN, HIT: state_nx = hit_next ? HIT : RUN;
                default:  state_nx = IDLE;
            endcase
        end
    end

    // Outputs decoded from state only
    always_comb begin
        z     = (state == HIT);
        armed = (state != IDLE);
    end

    // Configuration, history, fill and hit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat       <= '0;
            len       <= '0;
            ovl       <= 1'b0;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else if (load) begin
            if (load_ok) begin
                pat       <= pat_in;
                len       <= len_eff;
                ovl       <= ovl_in;
                hist      <= '0;
                fill      <= '0;
                match_cnt <= '0;
                cfg_err   <= 1'b0;
            end else begin
                cfg_err   <= 1'b1;
            end
        end else if (sampling) begin
            hist <= hist_nx;
            if (hit_next) begin
                // Non-overlap restarts the fill so the next match needs len fresh samples
                fill <= ovl ? fill_inc : '0;
                if (!cnt_full) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end else begin
                fill <= fill_inc;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus randomized traffic against a
// sample-queue reference model; two instances share stimulus (CNT_W = 8 and CNT_W = 2).
module tb_seq_detect_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] pat_in = '0;
    logic [3:0] len_in = '0;
    logic       ovl_in = 1'b0;
    logic       en = 1'b0;
    logic       x = 1'b0;

    logic       z_a, armed_a, cfg_err_a;
    logic [7:0] cnt_a;
    logic       z_b, armed_b, cfg_err_b;
    logic [1:0] cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit         m_armed, m_z, m_cfg_err, m_ovl;
    int         m_len;
    logic [7:0] m_pat;
    bit         hist_q[$];
    int         fresh;
    int         hits;

    always #5 clk = ~clk;

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .load(load), .pat_in(pat_in), .len_in(len_in),
        .ovl_in(ovl_in), .en(en), .x(x), .z(z_a), .match_cnt(cnt_a),
        .armed(armed_a), .cfg_err(cfg_err_a)
    );

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .load(load), .pat_in(pat_in), .len_in(len_in),
        .ovl_in(ovl_in), .en(en), .x(x), .z(z_b), .match_cnt(cnt_b),
        .armed(armed_b), .cfg_err(cfg_err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_z = 0; m_cfg_err = 0; m_ovl = 0;
        m_len = 0; m_pat = '0; fresh = 0; hits = 0;
        hist_q.delete();
    endtask

    // One clock edge of the specified behaviour, using the inputs present at that edge
    task automatic model_edge();
        bit match;
        if (load) begin
            if (len_in == 0) begin
                m_cfg_err = 1; m_armed = 0; m_z = 0;
            end else begin
                m_pat = pat_in; m_len = (len_in > 8) ? 8 : int'(len_in); m_ovl = ovl_in;
                hist_q.delete(); fresh = 0; hits = 0;
                m_cfg_err = 0; m_armed = 1; m_z = 0;
            end
        end else if (m_armed && en) begin
            hist_q.push_back(x);
            if (hist_q.size() > 8) void'(hist_q.pop_front());
            fresh++;
            match = (fresh >= m_len);
            if (match) begin
                for (int i = 0; i < m_len; i++) begin
                    if (hist_q[hist_q.size() - 1 - i] != m_pat[i]) match = 0;
                end
            end
            m_z = match;
            if (match) begin
                hits++;
                if (!m_ovl) fresh = 0;
            end
        end else begin
            m_z = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".z_a"},       z_a,       m_z);
        check({tag, ".z_b"},       z_b,       m_z);
        check({tag, ".armed_a"},   armed_a,   m_armed);
        check({tag, ".armed_b"},   armed_b,   m_armed);
        check({tag, ".cfg_err_a"}, cfg_err_a, m_cfg_err);
        check({tag, ".cfg_err_b"}, cfg_err_b, m_cfg_err);
        check({tag, ".cnt_a"},     cnt_a,     sat(hits, 255));
        check({tag, ".cnt_b"},     cnt_b,     sat(hits, 3));
    endtask

    task automatic step(input string tag, input bit l, input logic [7:0] p, input logic [3:0] n,
                        input bit o, input bit e, input bit xv);
        load = l; pat_in = p; len_in = n; ovl_in = o; en = e; x = xv;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_load(input string tag, input logic [7:0] p, input logic [3:0] n, input bit o);
        step(tag, 1'b1, p, n, o, 1'b1, 1'b1);
    endtask

    task automatic sample(input string tag, input bit e, input bit xv);
        step(tag, 1'b0, pat_in, len_in, ovl_in, e, xv);
    endtask

    // Called shortly after a posedge; reset lands between edges
    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1 rst = 1'b1;
    endtask

    initial begin
        bit s1011[7] = '{1, 0, 1, 1, 0, 1, 1};
        model_reset();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        // 1: overlapping 1011
        do_load("t1.load", 8'h0B, 4'd4, 1'b1);
        foreach (s1011[i]) sample("t1", 1'b1, s1011[i]);
        check("t1.cnt", cnt_a, 2);
        check("t1.armed", armed_a, 1);

        // 2: non-overlapping 1011
        do_load("t2.load", 8'h0B, 4'd4, 1'b0);
        foreach (s1011[i]) sample("t2", 1'b1, s1011[i]);
        check("t2.cnt", cnt_a, 1);

        // 3: rejected length, then clamped length
        do_load("t3.bad", 8'h0B, 4'd0, 1'b1);
        check("t3.cfg_err", cfg_err_a, 1);
        for (int i = 0; i < 8; i++) sample("t3.idle", 1'b1, 1'($urandom));
        check("t3.z_idle", z_a, 0);
        do_load("t3.clamp", 8'hFF, 4'd12, 1'b1);
        for (int i = 0; i < 7; i++) sample("t3.ones", 1'b1, 1'b1);
        check("t3.z_pre", z_a, 0);
        sample("t3.eighth", 1'b1, 1'b1);
        check("t3.z_hit", z_a, 1);
        check("t3.cfg_ok", cfg_err_a, 0);

        // 4: en gaps between samples
        do_load("t4.load", 8'h0B, 4'd4, 1'b1);
        sample("t4", 1'b1, 1'b1); sample("t4", 1'b0, 1'b1);
        sample("t4", 1'b1, 1'b0); sample("t4", 1'b0, 1'b1);
        sample("t4", 1'b1, 1'b1); sample("t4", 1'b0, 1'b0);
        check("t4.z_pre", z_a, 0);
        sample("t4", 1'b1, 1'b1);
        check("t4.z_hit", z_a, 1);
        sample("t4", 1'b0, 1'b1);
        check("t4.z_width", z_a, 0);

        // 5: length 1, saturation of the 2-bit counter
        do_load("t5.load", 8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) sample("t5", 1'b1, 1'b1);
        check("t5.cnt_b", cnt_b, 3);
        check("t5.cnt_a", cnt_a, 5);

        // 6: async reset mid-pattern and during HIT
        do_load("t6.load", 8'h0B, 4'd4, 1'b1);
        sample("t6", 1'b1, 1'b1); sample("t6", 1'b1, 1'b0); sample("t6", 1'b1, 1'b1);
        async_reset("t6.arst_mid");
        for (int i = 0; i < 6; i++) sample("t6.idle", 1'b1, 1'($urandom));
        do_load("t6.reload", 8'h0B, 4'd4, 1'b1);
        foreach (s1011[i]) if (i < 4) sample("t6", 1'b1, s1011[i]);
        check("t6.in_hit", z_a, 1);
        async_reset("t6.arst_hit");
        check("t6.z_after", z_a, 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                logic [3:0] n;
                n = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 12)) : 4'($urandom_range(1, 4));
                step("rnd.load", 1'b1, 8'($urandom), n, 1'($urandom), 1'($urandom), 1'($urandom));
            end else if (r == 3) begin
                async_reset("rnd.arst");
            end else begin
                sample("rnd", $urandom_range(0, 3) != 0, 1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Programmable Moore-type serial pattern detector, successor to the team's fixed-pattern detectors.
- Watches a 1-bit serial stream `x` qualified by `en`. Runs a pattern of 1..MAX_LEN bits, loaded at run time.
- Supports overlapping or non-overlapping detection and keeps a saturating hit counter.
- Sits in the serial front end. Control logic loads the pattern, then monitors `z` and `match_cnt`.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of the pattern-length field.
- CNT_W, 8, width of the hit counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- load  input  1  capture `pat_in`, `len_in` and `ovl_in` into config registers.
- pat_in  input  MAX_LEN  pattern. Bit [len-1] is the first bit received; bit [0] is the last.
- len_in  input  LEN_W  pattern length.
- ovl_in  input  1  1 = overlapping detection, 0 = non-overlapping.
- en  input  1  `x` is a valid sample this cycle.
- x  input  1  serial data bit.
- z  output  1  Moore detect output; high exactly while in state HIT.
- match_cnt  output  CNT_W  number of hits since the last load; saturates at all-ones.
- armed  output  1  a valid pattern is loaded (state != IDLE).
- cfg_err  output  1  last load was rejected (`len_in == 0`).

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - state = IDLE; history, fill, config, `match_cnt` = 0.
  - `z` = 0, `armed` = 0, `cfg_err` = 0.
  - Takes effect mid-stream immediately; a pending hit is lost.
- State register, 3 states:
  - IDLE: `en`/`x` ignored. `z` = 0.
  - RUN: sampling. `z` = 0.
  - HIT: sampling. `z` = 1.
  - `z` and `armed` are decoded from state only; no combinational path from `x`.
- Load (checked first every cycle, has priority over `en`):
  - If `len_in` == 0: `cfg_err` <= 1, state <= IDLE, config unchanged.
  - Else: config <= inputs, with length clamped to MAX_LEN if `len_in` > MAX_LEN. History, fill, `match_cnt` and `cfg_err` are cleared; state <= RUN.
  - A sample presented in the load cycle is discarded.
- Sampling (state RUN or HIT, `en` = 1, no load):
  - history <= {history[MAX_LEN-2:0], x}.
  - fill <= min(fill+1, MAX_LEN).
  - hit_next = (new fill >= len) AND (new history[len-1:0] == pat[len-1:0]).
  - If hit_next: state <= HIT, `match_cnt` <= `match_cnt`+1 unless all-ones. In non-overlap mode, fill <= 0 instead of the increment.
  - Else state <= RUN.
- Latency: the sample presented at edge k that completes a pattern drives `z` high from just after edge k until edge k+1. That is one cycle of latency and a one-cycle pulse.
- Back-to-back hits on consecutive samples keep state in HIT, so `z` stays high across those cycles.
- HIT with `en` = 0 and no load: state <= RUN (`z` drops); history and fill hold.
- RUN with `en` = 0: everything holds.
- Overlap mode: bits of a matched pattern count toward the next match, e.g. 1011 then 011 gives a second hit.
- Non-overlap mode: a new match needs `len` fresh samples after the previous hit.
- `match_cnt` saturates: at all-ones it stays all-ones on further hits; `z` still pulses.
- `cfg_err` stays set until the next valid load or reset.

Test Plan:
1. Reset, then load `pat_in` = 8'h0B, `len_in` = 4, `ovl_in` = 1. Stream 1,0,1,1,0,1,1 with `en` = 1 → `z` high the cycle after samples 4 and 7 only; `match_cnt` = 2; `armed` = 1.
2. Same pattern with `ovl_in` = 0, same stream → single `z` pulse after sample 4; `match_cnt` = 1.
3. `len_in` = 0 → `cfg_err` = 1, `armed` = 0, `z` stays 0 for any stream. Then load `len_in` = 12 with MAX_LEN = 8 and `pat_in` = 8'hFF, stream 8 ones → `cfg_err` = 0, hit after the 8th one (clamped length).
4. Pattern 1011 overlap; stream 1,0,1 with `en` toggling 1,0,1,0,1 between samples, then 1 → hit only after the fourth valid sample; `z` unaffected by idle cycles; `z` width is one cycle.
5. CNT_W = 2, `len_in` = 1, `pat_in` = 1, stream five ones → `z` high for 5 consecutive cycles; `match_cnt` = 3 (saturated).
6. Assert `rst` = 0 asynchronously mid-pattern and during HIT → `z`, `match_cnt`, `armed` = 0 immediately. After release, stream ignored (IDLE) until the next load.
